// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter that shares one N:1 mux among N requesters, with a
// per-tenure hold limit and a one-cycle break-before-make bubble between grants.
module mux16_rr_arbiter #(
  parameter int N        = 16,
  parameter int SEL_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             rel,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             owner_busy
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t            r_state;
  logic [SEL_W-1:0]  r_ptr;
  logic [HOLD_W-1:0] r_hold;
  logic [N-1:0]      r_gnt;
  logic [SEL_W-1:0]  r_sel;
  logic              r_valid;

  state_t            w_state_nxt;
  logic [SEL_W-1:0]  w_ptr_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [N-1:0]      w_gnt_nxt;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic              w_valid_nxt;

  logic              w_pick_found;
  logic [SEL_W-1:0]  w_pick_idx;
  logic [N-1:0]      w_others;
  logic              w_busy;
  logic              w_release;

  // Wrap-around priority scan starting at the rotating pointer.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = {SEL_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (!w_pick_found && req[r_ptr + SEL_W'(i)]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = r_ptr + SEL_W'(i);
      end else begin
        w_pick_found = w_pick_found;
      end
    end
  end

  // r_gnt is one-hot on the owner while granted, so masking it leaves the competitors.
  assign w_others   = req & ~r_gnt;
  assign w_busy     = (r_state == ST_GRANT) && (r_hold == HOLD_MAX) && (|w_others);
  assign w_release  = !req[r_sel] || rel || w_busy;
  assign owner_busy = w_busy;

  // Next-state and next-output decode for the IDLE/GRANT controller.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << w_pick_idx;
          w_sel_nxt   = w_pick_idx;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = {HOLD_W{1'b0}};
        end else begin
          w_gnt_nxt   = {N{1'b0}};
          w_valid_nxt = 1'b0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = {N{1'b0}};
          w_valid_nxt = 1'b0;
          w_ptr_nxt   = r_sel + SEL_W'(1);
          w_hold_nxt  = {HOLD_W{1'b0}};
        end else if (r_hold != HOLD_MAX) begin
          w_hold_nxt  = r_hold + HOLD_W'(1);
        end else begin
          w_hold_nxt  = r_hold;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = {N{1'b0}};
        w_valid_nxt = 1'b0;
        w_hold_nxt  = {HOLD_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs; sel deliberately holds its value across the bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= {SEL_W{1'b0}};
      r_hold  <= {HOLD_W{1'b0}};
      r_gnt   <= {N{1'b0}};
      r_sel   <= {SEL_W{1'b0}};
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign sel_valid = r_valid;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: directed scenarios plus a
// randomized run against an owner/age reference model.
module tb_mux16_rr_arbiter;

  localparam int N        = 16;
  localparam int SEL_W    = 4;
  localparam int MAX_HOLD = 8;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic             rel;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             owner_busy;

  int n_checks;
  int n_fail;

  // reference model: owner index (-1 = none), age since grant (unbounded), pointer, last select
  int   m_owner;
  int   m_age;
  int   m_ptr;
  int   m_sel;
  logic obs_busy;
  logic exp_busy;

  mux16_rr_arbiter #(.N(N), .SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .rel        (rel),
    .gnt        (gnt),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .owner_busy (owner_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_busy();
    logic [N-1:0] others;
    if (m_owner < 0) return 1'b0;
    others = req;
    others[m_owner] = 1'b0;
    return (m_age >= MAX_HOLD - 1) && (others != 16'h0000);
  endfunction

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] one;
    one = 16'h0001;
    if (m_owner < 0) return 16'h0000;
    return one << m_owner;
  endfunction

  task automatic model_edge();
    logic [N-1:0] others;
    if (rst) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_sel   = m_owner;
          m_age   = 0;
        end
      end
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      if (!req[m_owner] || rel || (m_age >= MAX_HOLD - 1 && others != 16'h0000)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_age   = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
  endtask

  // Drive one cycle of inputs, capture owner_busy before the edge, then advance the model.
  task automatic tick(input logic [N-1:0] r, input logic s_rel, input logic s_rst);
    @(negedge clk);
    req = r; rel = s_rel; rst = s_rst;
    #1;
    obs_busy = owner_busy;
    exp_busy = model_busy();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    tick(16'h0000, 1'b0, 1'b1);
    tick(16'hffff, 1'b1, 1'b1);
    n_checks++; if (gnt !== 16'h0000) begin n_fail++; $display("FAIL reset_gnt got=%h want=%h", gnt, 16'h0000); end
    n_checks++; if (sel !== 4'd0) begin n_fail++; $display("FAIL reset_sel got=%0d want=0", sel); end
    n_checks++; if (sel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", sel_valid); end
  endtask

  task automatic test_reset_mid_grant();
    tick(16'h0000, 1'b0, 1'b1);
    tick(16'h0020, 1'b0, 1'b0);
    n_checks++; if (gnt !== 16'h0020 || sel !== 4'd5) begin n_fail++; $display("FAIL midrst_grant5 got=%h/%0d want=0020/5", gnt, sel); end
    tick(16'h0020, 1'b0, 1'b0);
    tick(16'h0020, 1'b0, 1'b1);
    n_checks++; if (gnt !== 16'h0000 || sel !== 4'd0 || sel_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_drop got=%h/%0d/%b want=0000/0/0", gnt, sel, sel_valid); end
    tick(16'h0021, 1'b0, 1'b0);
    n_checks++; if (gnt !== 16'h0001 || sel !== 4'd0 || sel_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_regrant got=%h/%0d/%b want=0001/0/1", gnt, sel, sel_valid); end
  endtask

  task automatic test_single();
    tick(16'h0000, 1'b0, 1'b1);
    tick(16'h0040, 1'b0, 1'b0);
    n_checks++; if (gnt !== 16'h0040 || sel !== 4'd6 || sel_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_grant got=%h/%0d/%b want=0040/6/1", gnt, sel, sel_valid); end
    tick(16'h0000, 1'b0, 1'b0);
    n_checks++; if (gnt !== 16'h0000 || sel_valid !== 1'b0 || sel !== 4'd6) begin
      n_fail++; $display("FAIL single_release got=%h/%b/%0d want=0000/0/6", gnt, sel_valid, sel); end
    // ptr should now be 7: with 6 and 7 both requesting, 7 wins
    tick(16'h00c0, 1'b0, 1'b0);
    n_checks++; if (sel !== 4'd7 || gnt !== 16'h0080) begin n_fail++; $display("FAIL single_ptr7 got=%0d/%h want=7/0080", sel, gnt); end
  endtask

  task automatic test_rotation();
    int exp_order[9] = '{1, 3, 8, 9, 10, 11, 12, 13, 1};
    int order[$];
    int lens[$];
    int gaps[$];
    int run, gap, busy_cnt;
    logic prev_v;
    tick(16'h0000, 1'b0, 1'b1);
    prev_v = 1'b0; run = 0; gap = 0; busy_cnt = 0;
    for (int c = 0; c < 150 && order.size() < 9; c++) begin
      tick(16'h3f0a, 1'b0, 1'b0);
      if (obs_busy) busy_cnt++;
      if (sel_valid && !prev_v) begin
        order.push_back(int'(sel));
        if (order.size() > 1) gaps.push_back(gap);
        run = 1;
      end else if (sel_valid) begin
        run++;
      end else if (prev_v) begin
        lens.push_back(run);
        gap = 1;
      end else begin
        gap++;
      end
      prev_v = sel_valid;
    end
    n_checks++; if (order.size() != 9) begin n_fail++; $display("FAIL rot_timeout got=%0d grants want=9", order.size()); end
    for (int i = 0; i < order.size(); i++) begin
      n_checks++; if (order[i] != exp_order[i]) begin n_fail++; $display("FAIL rot_order[%0d] got=%0d want=%0d", i, order[i], exp_order[i]); end
    end
    for (int i = 0; i < lens.size(); i++) begin
      n_checks++; if (lens[i] != MAX_HOLD) begin n_fail++; $display("FAIL rot_len[%0d] got=%0d want=%0d", i, lens[i], MAX_HOLD); end
    end
    for (int i = 0; i < gaps.size(); i++) begin
      n_checks++; if (gaps[i] != 1) begin n_fail++; $display("FAIL rot_bubble[%0d] got=%0d want=1", i, gaps[i]); end
    end
    n_checks++; if (busy_cnt != 8) begin n_fail++; $display("FAIL rot_busy_pulses got=%0d want=8", busy_cnt); end
  endtask

  task automatic test_wrap();
    int exp_order[3] = '{15, 0, 1};
    int order[$];
    logic prev_v;
    tick(16'h0000, 1'b0, 1'b1);
    tick(16'h1000, 1'b0, 1'b0);
    tick(16'h0000, 1'b0, 1'b0);
    prev_v = 1'b0;
    for (int c = 0; c < 60 && order.size() < 3; c++) begin
      tick(16'h8003, 1'b0, 1'b0);
      if (sel_valid && !prev_v) order.push_back(int'(sel));
      prev_v = sel_valid;
    end
    n_checks++; if (order.size() != 3) begin n_fail++; $display("FAIL wrap_timeout got=%0d grants want=3", order.size()); end
    for (int i = 0; i < order.size(); i++) begin
      n_checks++; if (order[i] != exp_order[i]) begin n_fail++; $display("FAIL wrap_order[%0d] got=%0d want=%0d", i, order[i], exp_order[i]); end
    end
  endtask

  task automatic test_rel_and_saturation();
    tick(16'h0000, 1'b0, 1'b1);
    tick(16'h1000, 1'b0, 1'b0);
    n_checks++; if (sel !== 4'd12 || sel_valid !== 1'b1) begin n_fail++; $display("FAIL rel_grant12 got=%0d/%b want=12/1", sel, sel_valid); end
    tick(16'h5008, 1'b0, 1'b0);
    tick(16'h5008, 1'b0, 1'b0);
    n_checks++; if (gnt !== 16'h1000) begin n_fail++; $display("FAIL rel_no_preempt got=%h want=1000", gnt); end
    tick(16'h5008, 1'b1, 1'b0);
    n_checks++; if (gnt !== 16'h0000 || sel_valid !== 1'b0 || sel !== 4'd12) begin
      n_fail++; $display("FAIL rel_release got=%h/%b/%0d want=0000/0/12", gnt, sel_valid, sel); end
    tick(16'h5008, 1'b0, 1'b0);
    n_checks++; if (sel !== 4'd14 || gnt !== 16'h4000) begin n_fail++; $display("FAIL rel_next got=%0d/%h want=14/4000", sel, gnt); end
    tick(16'h0000, 1'b0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick(16'h0010, 1'b0, 1'b0);
      n_checks++; if (gnt !== 16'h0010 || owner_busy !== 1'b0) begin
        n_fail++; $display("FAIL sat_hold[%0d] got=%h/%b want=0010/0", c, gnt, owner_busy); end
    end
    tick(16'h0011, 1'b0, 1'b0);
    n_checks++; if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL sat_busy got=%b want=1", obs_busy); end
    n_checks++; if (gnt !== 16'h0000) begin n_fail++; $display("FAIL sat_release got=%h want=0000", gnt); end
    tick(16'h0011, 1'b0, 1'b0);
    n_checks++; if (gnt !== 16'h0001 || sel !== 4'd0) begin n_fail++; $display("FAIL sat_grant0 got=%h/%0d want=0001/0", gnt, sel); end
  endtask

  task automatic test_drop_and_rel();
    tick(16'h0000, 1'b0, 1'b1);
    tick(16'h0200, 1'b0, 1'b0);
    n_checks++; if (sel !== 4'd9 || gnt !== 16'h0200) begin n_fail++; $display("FAIL droprel_grant9 got=%0d/%h want=9/0200", sel, gnt); end
    tick(16'h0401, 1'b1, 1'b0);
    n_checks++; if (gnt !== 16'h0000) begin n_fail++; $display("FAIL droprel_release got=%h want=0000", gnt); end
    tick(16'h0401, 1'b0, 1'b0);
    n_checks++; if (sel !== 4'd10 || gnt !== 16'h0400) begin n_fail++; $display("FAIL droprel_next got=%0d/%h want=10/0400", sel, gnt); end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] eg;
    tick(16'h0000, 1'b0, 1'b1);
    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 3))
        0: r = 16'h0000;
        1: r = 16'h0001 << $urandom_range(0, 15);
        2: r = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: r = 16'($urandom);
      endcase
      // hold the owner's request most of the time so tenures reach the hold limit
      if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
      tick(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0));
      eg = model_gnt();
      n_checks++; if (obs_busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, obs_busy, exp_busy); end
      n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL rnd_gnt c=%0d got=%h want=%h", c, gnt, eg); end
      n_checks++; if (sel_valid !== (m_owner >= 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, sel_valid, (m_owner >= 0)); end
      n_checks++; if (sel !== SEL_W'(m_sel)) begin n_fail++; $display("FAIL rnd_sel c=%0d got=%0d want=%0d", c, sel, m_sel); end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_owner = -1; m_age = 0; m_ptr = 0; m_sel = 0;
    obs_busy = 1'b0; exp_busy = 1'b0;
    rst = 1'b1; req = 16'h0000; rel = 1'b0;
    test_reset();
    test_reset_mid_grant();
    test_single();
    test_rotation();
    test_wrap();
    test_rel_and_saturation();
    test_drop_and_rel();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
